// File: rtl/tri_bus_arbiter.sv
// rtl/tri_bus_arbiter.sv - four-requester round-robin tri-state bus arbiter with turnaround cycle
// Optional owner tenure limit enabled by defining TRI_BUS_TIMEOUT_EN.
module tri_bus_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_HOLD   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3:0]              req,
    input  logic [4*DATA_WIDTH-1:0] data_in,
    output logic [3:0]              grant,
    output logic [3:0]              oe,
    output logic [DATA_WIDTH-1:0]   y_out,
    output logic                    bus_idle,
    output logic                    timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN  = 2'd1,
        S_TURN = 2'd2
    } state_t;

    state_t     r_state;
    logic [3:0] r_grant;
    logic [1:0] r_owner;
    logic [1:0] r_last;
    logic       r_bus_idle;
    logic       r_timeout;

    logic       w_found;
    logic [1:0] w_win_idx;
    logic [DATA_WIDTH-1:0] w_sel;

`ifdef TRI_BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    logic [CNT_W-1:0] r_cnt;
`else
    logic w_unused_max_hold;
    assign w_unused_max_hold = (MAX_HOLD == 0);
`endif

    // Search starts one past the last owner; the last owner is tried last.
    always_comb begin
        w_found   = 1'b0;
        w_win_idx = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            logic [1:0] v_cand;
            v_cand = r_last + 2'(k);
            if (!w_found && req[v_cand]) begin
                w_found   = 1'b1;
                w_win_idx = v_cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_grant    <= 4'b0000;
            r_owner    <= 2'd0;
            r_last     <= 2'd3;
            r_bus_idle <= 1'b1;
            r_timeout  <= 1'b0;
`ifdef TRI_BUS_TIMEOUT_EN
            r_cnt      <= '0;
`endif
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE, S_TURN: begin
                    if (w_found) begin
                        r_state    <= S_OWN;
                        r_grant    <= 4'b0001 << w_win_idx;
                        r_owner    <= w_win_idx;
                        r_bus_idle <= 1'b0;
`ifdef TRI_BUS_TIMEOUT_EN
                        r_cnt      <= CNT_W'(1);
`endif
                    end else begin
                        r_state    <= S_IDLE;
                        r_grant    <= 4'b0000;
                        r_bus_idle <= 1'b1;
                    end
                end
                S_OWN: begin
                    if (!req[r_owner]) begin
                        r_state    <= S_TURN;
                        r_grant    <= 4'b0000;
                        r_last     <= r_owner;
                        r_bus_idle <= 1'b0;
                    end
`ifdef TRI_BUS_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(MAX_HOLD)) begin
                        r_state    <= S_TURN;
                        r_grant    <= 4'b0000;
                        r_last     <= r_owner;
                        r_bus_idle <= 1'b0;
                        r_timeout  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
`endif
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_grant    <= 4'b0000;
                    r_bus_idle <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < 4; i++) begin
            if (r_grant[i]) begin
                w_sel = data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign grant    = r_grant;
    assign oe       = r_grant;
    assign bus_idle = r_bus_idle;
    assign timeout  = r_timeout;
    assign y_out    = (|r_grant) ? w_sel : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// tb/tb_tri_bus_arbiter.sv - self-checking bench for tri_bus_arbiter with a behavioural owner model
module tb_tri_bus_arbiter;

    localparam int DW = 8;
    localparam int HOLD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    req = 4'b0000;
    logic [4*DW-1:0] data_in = '0;
    logic [3:0]    grant;
    logic [3:0]    oe;
    logic [DW-1:0] y_out;
    logic          bus_idle;
    logic          timeout;

    int checks = 0;
    int failures = 0;

    // Behavioural model: who owns the bus, whether a gap cycle is in progress.
    int m_owner;
    int m_last;
    int m_tenure;
    bit m_gap;
    bit m_to;

    tri_bus_arbiter #(.DATA_WIDTH(DW), .MAX_HOLD(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in),
        .grant(grant), .oe(oe), .y_out(y_out), .bus_idle(bus_idle), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = -1; m_last = 3; m_tenure = 0; m_gap = 0; m_to = 0;
    endtask

    task automatic model_edge(input logic [3:0] r);
        bit limit;
        limit = 0;
`ifdef TRI_BUS_TIMEOUT_EN
        limit = 1;
`endif
        m_to = 0;
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_last = m_owner; m_owner = -1; m_gap = 1;
            end else if (limit && m_tenure == HOLD) begin
                m_last = m_owner; m_owner = -1; m_gap = 1; m_to = 1;
            end else begin
                m_tenure++;
            end
        end else begin
            m_gap = 0;
            for (int k = 1; k <= 4; k++) begin
                if (m_owner < 0 && r[(m_last + k) % 4]) begin
                    m_owner = (m_last + k) % 4;
                    m_tenure = 1;
                end
            end
        end
    endtask

    task automatic step(input logic [3:0] r);
        req = r;
        for (int i = 0; i < 4; i++) data_in[i*DW +: DW] = 8'($urandom_range(1, 255));
        @(posedge clk);
        model_edge(r);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        step(4'b1111);
        step(4'b1111);
        rst_n = 1'b0;
        #1;
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        checks++; if (oe !== 4'b0000) begin failures++; $display("FAIL reset_oe got=%b exp=0000", oe); end
        checks++; if (bus_idle !== 1'b1) begin failures++; $display("FAIL reset_bus_idle got=%b exp=1", bus_idle); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        checks++; if (!(y_out === 8'hzz || y_out === 8'h00)) begin failures++; $display("FAIL reset_y_out got=%h exp=zz", y_out); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_first_grant();
        do_reset();
        req = 4'b0001;
        data_in = '0;
        data_in[7:0] = 8'hA5;
        @(posedge clk);
        model_edge(req);
        @(negedge clk);
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL first_grant got=%b exp=0001", grant); end
        checks++; if (oe !== 4'b0001) begin failures++; $display("FAIL first_oe got=%b exp=0001", oe); end
        checks++; if (y_out !== 8'hA5) begin failures++; $display("FAIL first_y_out got=%h exp=a5", y_out); end
        checks++; if (bus_idle !== 1'b0) begin failures++; $display("FAIL first_bus_idle got=%b exp=0", bus_idle); end
    endtask

    task automatic test_rotation();
        logic [3:0] rv;
        logic [3:0] exp_g;
        do_reset();
        rv = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            exp_g = 4'b0001 << k;
            for (int c = 0; c < 2; c++) begin
                step(rv);
                checks++; if (grant !== exp_g) begin failures++; $display("FAIL rot_grant k=%0d got=%b exp=%b", k, grant, exp_g); end
                checks++; if (y_out !== data_in[k*DW +: DW]) begin failures++; $display("FAIL rot_y_out k=%0d got=%h exp=%h", k, y_out, data_in[k*DW +: DW]); end
            end
            rv[k] = 1'b0;
            step(rv);
            checks++; if (oe !== 4'b0000) begin failures++; $display("FAIL rot_turn_oe k=%0d got=%b exp=0000", k, oe); end
            checks++; if (bus_idle !== 1'b0) begin failures++; $display("FAIL rot_turn_idle k=%0d got=%b exp=0", k, bus_idle); end
            checks++; if (!(y_out === 8'hzz || y_out === 8'h00)) begin failures++; $display("FAIL rot_turn_y_out k=%0d got=%h exp=zz", k, y_out); end
        end
        step(4'b0000);
        checks++; if (bus_idle !== 1'b1) begin failures++; $display("FAIL rot_end_idle got=%b exp=1", bus_idle); end
    endtask

    task automatic test_handover();
        do_reset();
        step(4'b0001);
        step(4'b0111);
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL hand_hold got=%b exp=0001", grant); end
        step(4'b0110);
        checks++; if (oe !== 4'b0000) begin failures++; $display("FAIL hand_turn got=%b exp=0000", oe); end
        step(4'b0110);
        checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL hand_next got=%b exp=0010", grant); end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(4'b0001);
        step(4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL areset_grant got=%b exp=0000", grant); end
        checks++; if (!(y_out === 8'hzz || y_out === 8'h00)) begin failures++; $display("FAIL areset_y_out got=%h exp=zz", y_out); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL areset_release got=%b exp=0000", grant); end
        @(negedge clk);
        model_edge(req);
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL areset_regrant got=%b exp=0001", grant); end
    endtask

    task automatic test_pulse();
        do_reset();
        step(4'b0100);
        checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL pulse_own got=%b exp=0100", grant); end
        step(4'b0000);
        checks++; if (grant !== 4'b0000 || bus_idle !== 1'b0) begin failures++; $display("FAIL pulse_turn got=%b/%b exp=0000/0", grant, bus_idle); end
        step(4'b0000);
        checks++; if (bus_idle !== 1'b1) begin failures++; $display("FAIL pulse_idle got=%b exp=1", bus_idle); end
    endtask

`ifdef TRI_BUS_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        for (int c = 0; c < HOLD; c++) begin
            step(4'b0011);
            checks++; if (grant !== 4'b0001 || timeout !== 1'b0) begin failures++; $display("FAIL to_hold c=%0d got=%b/%b exp=0001/0", c, grant, timeout); end
        end
        step(4'b0011);
        checks++; if (grant !== 4'b0000 || timeout !== 1'b1) begin failures++; $display("FAIL to_pulse got=%b/%b exp=0000/1", grant, timeout); end
        step(4'b0011);
        checks++; if (grant !== 4'b0010 || timeout !== 1'b0) begin failures++; $display("FAIL to_next got=%b/%b exp=0010/0", grant, timeout); end
    endtask
`endif

    task automatic test_random();
        logic [3:0] rv;
        logic [3:0] exp_g;
        logic [3:0] prev_g;
        do_reset();
        rv = 4'b0000;
        prev_g = 4'b0000;
        for (int n = 0; n < 400; n++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) rv[b] = ~rv[b];
            step(rv);
            exp_g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
            checks++; if (grant !== exp_g) begin failures++; $display("FAIL rnd_grant n=%0d got=%b exp=%b", n, grant, exp_g); end
            checks++; if (oe !== exp_g) begin failures++; $display("FAIL rnd_oe n=%0d got=%b exp=%b", n, oe, exp_g); end
            checks++; if (bus_idle !== (m_owner < 0 && !m_gap)) begin failures++; $display("FAIL rnd_idle n=%0d got=%b exp=%b", n, bus_idle, (m_owner < 0 && !m_gap)); end
            checks++; if (timeout !== m_to) begin failures++; $display("FAIL rnd_timeout n=%0d got=%b exp=%b", n, timeout, m_to); end
            if (m_owner >= 0) begin
                checks++; if (y_out !== data_in[m_owner*DW +: DW]) begin failures++; $display("FAIL rnd_y_out n=%0d got=%h exp=%h", n, y_out, data_in[m_owner*DW +: DW]); end
            end else begin
                checks++; if (!(y_out === 8'hzz || y_out === 8'h00)) begin failures++; $display("FAIL rnd_y_out n=%0d got=%h exp=zz", n, y_out); end
            end
            checks++; if (prev_g != 4'b0000 && grant != 4'b0000 && prev_g != grant) begin failures++; $display("FAIL rnd_no_gap n=%0d got=%b prev=%b exp=gap", n, grant, prev_g); end
            prev_g = grant;
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_first_grant();
        test_rotation();
        test_handover();
        test_async_reset();
        test_pulse();
`ifdef TRI_BUS_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
